// File: rtl/fb_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_read_arbiter_pkg
// Description : Shared types and default widths for the frame-buffer read
//               arbiter (state encoding, requester id, pixel/word widths).
// Revision    : 1.0 - initial release
// ============================================================================
package fb_read_arbiter_pkg;

    localparam int c_nb_img_pxls = 17;  // 320x240 pixel address
    localparam int c_nb_buf      = 12;  // 4:4:4 RGB word

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic req_id_t;

endpackage
`default_nettype wire

// File: rtl/fb_read_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fb_read_tag_pipe
// Description : Two-stage {valid, id} delay line matching the address
//               register plus the frame-buffer read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_read_tag_pipe
    import fb_read_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    in_valid,
    input  req_id_t in_id,
    output logic    out_valid,
    output req_id_t out_id
);

    logic    r_v1;
    logic    r_v2;
    req_id_t r_id1;
    req_id_t r_id2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_id1 <= 1'b0;
            r_id2 <= 1'b0;
        end else begin
            r_v1  <= in_valid;
            r_id1 <= in_id;
            r_v2  <= r_v1;
            r_id2 <= r_id1;
        end
    end

    assign out_valid = r_v2;
    assign out_id    = r_id2;

endmodule
`default_nettype wire

// File: rtl/fb_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_read_arbiter
// Description : Two-requester read arbiter for a single-port frame buffer
//               with lockable ownership. Define FB_READ_ARBITER_RR_EN for
//               round-robin conflict resolution (else requester 0 wins).
// Revision    : 1.0 - initial release
// ============================================================================
module fb_read_arbiter
    import fb_read_arbiter_pkg::*;
#(
    parameter int C_NB_IMG_PXLS = c_nb_img_pxls,
    parameter int C_NB_BUF      = c_nb_buf
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0,
    input  logic                     req1,
    input  logic [C_NB_IMG_PXLS-1:0] addr0,
    input  logic [C_NB_IMG_PXLS-1:0] addr1,
    input  logic                     lock0,
    input  logic                     lock1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     rvalid0,
    output logic                     rvalid1,
    output logic [C_NB_BUF-1:0]      rdata,
    output logic [C_NB_IMG_PXLS-1:0] mem_addr,
    input  logic [C_NB_BUF-1:0]      mem_dout
);

    arb_state_t               r_state;
    arb_state_t               w_next_state;
    logic                     w_gnt0;
    logic                     w_gnt1;
    logic                     w_arbitrate;
    logic                     w_pick1;
    logic [C_NB_IMG_PXLS-1:0] r_mem_addr;
    logic                     w_tag_valid;
    req_id_t                  w_tag_id;

`ifdef FB_READ_ARBITER_RR_EN
    logic r_rr_ptr;

    // Pointer follows the requester that lost each grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= 1'b0;
        end else if (gnt0) begin
            r_rr_ptr <= 1'b1;
        end else if (gnt1) begin
            r_rr_ptr <= 1'b0;
        end
    end

    assign w_pick1 = r_rr_ptr;
`else
    assign w_pick1 = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A dropped lock falls through to normal arbitration in the same cycle.
    always_comb begin
        w_next_state = r_state;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        w_arbitrate  = 1'b0;
        case (r_state)
            OWN0: begin
                if (lock0) w_gnt0 = req0;
                else       w_arbitrate = 1'b1;
            end
            OWN1: begin
                if (lock1) w_gnt1 = req1;
                else       w_arbitrate = 1'b1;
            end
            default: w_arbitrate = 1'b1;
        endcase
        if (w_arbitrate) begin
            w_next_state = IDLE;
            if (req0 && req1) begin
                w_gnt0 = ~w_pick1;
                w_gnt1 = w_pick1;
            end else begin
                w_gnt0 = req0;
                w_gnt1 = req1;
            end
            if (w_gnt0 && lock0)      w_next_state = OWN0;
            else if (w_gnt1 && lock1) w_next_state = OWN1;
        end
    end

    assign gnt0 = w_gnt0 & rst;
    assign gnt1 = w_gnt1 & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_addr <= '0;
        end else if (gnt0) begin
            r_mem_addr <= addr0;
        end else if (gnt1) begin
            r_mem_addr <= addr1;
        end
    end

    assign mem_addr = r_mem_addr;

    fb_read_tag_pipe u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (gnt0 | gnt1),
        .in_id     (gnt1),
        .out_valid (w_tag_valid),
        .out_id    (w_tag_id)
    );

    assign rvalid0 = w_tag_valid & (w_tag_id == 1'b0);
    assign rvalid1 = w_tag_valid & (w_tag_id == 1'b1);
    assign rdata   = mem_dout;

endmodule
`default_nettype wire

// File: tb/tb_fb_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_read_arbiter
// Description : Directed self-checking bench for fb_read_arbiter with a
//               behavioural 1-cycle-latency frame buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_read_arbiter;
    import fb_read_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
    logic [16:0] addr0 = '0, addr1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [11:0] rdata, mem_dout;
    logic [16:0] mem_addr;

    int n_vec = 0;
    int n_err = 0;
    int n_rv0 = 0;

    // bench model of the expected pipeline
    logic        eg0 = 1'b0, eg1 = 1'b0;
    logic [16:0] m_addr = '0;
    logic        s1_v = 1'b0, s1_id = 1'b0, s2_v = 1'b0, s2_id = 1'b0;
    logic [16:0] s1_addr = '0, s2_addr = '0;

    fb_read_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .addr0    (addr0),
        .addr1    (addr1),
        .lock0    (lock0),
        .lock1    (lock1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata    (rdata),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] img_word(input logic [16:0] a);
        return a[11:0] ^ {7'b0, a[16:12]} ^ 12'h5A3;
    endfunction

    always @(posedge clk) mem_dout <= img_word(mem_addr);

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_addr = '0;
        s1_v = 1'b0; s1_id = 1'b0; s1_addr = '0;
        s2_v = 1'b0; s2_id = 1'b0; s2_addr = '0;
    endtask

    task automatic check_outputs();
        check_value("mem_addr", mem_addr, m_addr);
        check_value("rvalid0", rvalid0, s2_v & ~s2_id);
        check_value("rvalid1", rvalid1, s2_v & s2_id);
        if (s2_v) check_value("rdata", rdata, img_word(s2_addr));
        if (rvalid0) n_rv0++;
    endtask

    task automatic step();
        @(posedge clk);
        s2_v = s1_v; s2_id = s1_id; s2_addr = s1_addr;
        s1_v = eg0 | eg1;
        s1_id = eg1;
        s1_addr = eg0 ? addr0 : addr1;
        if (eg0)      m_addr = addr0;
        else if (eg1) m_addr = addr1;
        #1;
        check_outputs();
    endtask

    // one arbitration cycle with hand-computed grants
    task automatic drive(input logic r0, input logic [16:0] a0, input logic l0,
                         input logic r1, input logic [16:0] a1, input logic l1,
                         input logic x0, input logic x1);
        req0 = r0; addr0 = a0; lock0 = l0;
        req1 = r1; addr1 = a1; lock1 = l1;
        eg0 = x0; eg1 = x1;
        #1;
        check_value("gnt0", gnt0, x0);
        check_value("gnt1", gnt1, x1);
        step();
    endtask

    task automatic reset_dut();
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
        eg0 = 0; eg1 = 0;
        rst = 1'b0;
        model_clear();
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        logic exp0;

        // reset state, request held during reset must not be granted
        req0 = 1'b1; addr0 = 17'h5;
        #12;
        check_value("rst_gnt0", gnt0, 1'b0);
        check_value("rst_mem_addr", mem_addr, 17'h0);
        check_value("rst_rvalid0", rvalid0, 1'b0);
        check_value("rst_rvalid1", rvalid1, 1'b0);
        check_value("rst_state", dut.r_state, IDLE);
        reset_dut();

        // single read from requester 0
        drive(1, 17'h00010, 0, 0, 17'h0, 0, 1, 0);
        drive(0, 17'h00010, 0, 0, 17'h0, 0, 0, 0);
        drive(0, 17'h00010, 0, 0, 17'h0, 0, 0, 0);
        drive(0, 17'h00010, 0, 0, 17'h0, 0, 0, 0);

        // continuous conflict for 6 cycles
        reset_dut();
        begin
            int c0 = 0, c1 = 0;
            for (int i = 0; i < 6; i++) begin
`ifdef FB_READ_ARBITER_RR_EN
                exp0 = (i % 2 == 0);
`else
                exp0 = 1'b1;
`endif
                drive(1, 17'h100 + c0, 0, 1, 17'h200 + c1, 0, exp0, ~exp0);
                if (exp0) c0++; else c1++;
            end
        end
        drive(0, '0, 0, 0, '0, 0, 0, 0);
        drive(0, '0, 0, 0, '0, 0, 0, 0);

        // requester 1 locks and keeps ownership against requester 0
        reset_dut();
        drive(0, 17'h80, 0, 1, 17'h40, 1, 0, 1);
        for (int i = 1; i <= 4; i++)
            drive(1, 17'h80, 0, 1, 17'h40 + i, 1, 0, 1);
        check_value("own1_state", dut.r_state, OWN1);
        drive(1, 17'h80, 0, 0, 17'h45, 0, 1, 0);
        check_value("unlock_state", dut.r_state, IDLE);
        drive(0, '0, 0, 0, '0, 0, 0, 0);
        drive(0, '0, 0, 0, '0, 0, 0, 0);

        // reset one cycle after a grant discards the read
        drive(1, 17'h55, 0, 0, '0, 0, 1, 0);
        rst = 1'b0;
        req0 = 1'b1;
        model_clear();
        eg0 = 0; eg1 = 0;
        #1;
        check_value("midrst_gnt0", gnt0, 1'b0);
        check_value("midrst_mem_addr", mem_addr, 17'h0);
        req0 = 1'b0;
        step();
        rst = 1'b1;
        drive(0, '0, 0, 0, '0, 0, 0, 0);
        drive(0, '0, 0, 0, '0, 0, 0, 0);
        check_value("postrst_state", dut.r_state, IDLE);

        // withdrawn request while requester 0 owns
        drive(1, 17'h300, 1, 0, '0, 0, 1, 0);
        drive(0, 17'h300, 1, 1, 17'h3FF, 0, 0, 0);
        drive(0, 17'h300, 0, 0, 17'h3FF, 0, 0, 0);
        drive(0, '0, 0, 0, '0, 0, 0, 0);
        drive(0, '0, 0, 0, '0, 0, 0, 0);

        // full-frame locked sequential read
        n_rv0 = 0;
        for (int i = 0; i < 76800; i++)
            drive(1, 17'(i), 1, 0, '0, 0, 1, 0);
        drive(0, '0, 0, 0, '0, 0, 0, 0);
        drive(0, '0, 0, 0, '0, 0, 0, 0);
        check_value("frame_rvalid_count", n_rv0, 76800);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
